// File: rtl/rou_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rou_pkg
// Purpose  : Shared rou message definitions: kind codes, field offsets,
//            byte-count width derivation and message-valid helper.
// Revision : 1.0 - initial release
// ============================================================================
package rou_pkg;

  localparam logic [1:0] KIND_EMPTY = 2'd0;
  localparam logic [1:0] KIND_WRITE = 2'd1;
  localparam logic [1:0] KIND_RDREQ = 2'd2;
  localparam logic [1:0] KIND_RDRSP = 2'd3;

  // Fixed low fields; the wider fields are placed by each user from its widths
  localparam int KIND_LSB = 0;
  localparam int KIND_W   = 2;
  localparam int ADDR_LSB = KIND_LSB + KIND_W;

  // Byte-count width follows the data width
  function automatic int rou_bwid(input int dwid);
    case (dwid)
      512:     return 6;
      256:     return 5;
      128:     return 4;
      64:      return 3;
      default: return 2;
    endcase
  endfunction

  // A message slot carries something whenever its kind is non-empty
  function automatic logic msgValid(input logic [1:0] kind);
    return kind != KIND_EMPTY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rou_tag_alloc.sv
`default_nettype none
// ============================================================================
// Module   : rou_tag_alloc
// Purpose  : Read-tag occupancy bitmap with lowest-free selection and
//            popcount of allocated tags.
// Revision : 1.0 - initial release
// ============================================================================
module rou_tag_alloc
  import rou_pkg::*;
#(
  parameter int OUTS = 8,
  parameter int TWID = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr,
  input  logic                       i_alloc,
  input  logic                       i_free,
  input  logic [TWID-1:0]            i_free_tag,
  output logic [OUTS-1:0]            o_map,
  output logic                       o_avail,
  output logic [TWID-1:0]            o_free_tag,
  output logic [$clog2(OUTS+1)-1:0]  o_count
);

  localparam int CW = $clog2(OUTS + 1);

  logic [OUTS-1:0] r_map;
  logic [OUTS-1:0] w_set;
  logic [OUTS-1:0] w_clr;
  logic            w_avail;
  logic [TWID-1:0] w_idx;
  logic [CW-1:0]   w_cnt;

  // Lowest clear bit of the registered map; a tag freed this cycle is not seen yet
  always_comb begin
    w_avail = 1'b0;
    w_idx   = '0;
    for (int i = OUTS - 1; i >= 0; i--) begin
      if (!r_map[i]) begin
        w_avail = 1'b1;
        w_idx   = TWID'(i);
      end
    end
  end

  // One-hot set/clear masks for this cycle's allocation and retirement
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < OUTS; i++) begin
      if (i_alloc && w_avail && (w_idx == TWID'(i))) w_set[i] = 1'b1;
      if (i_free && (i_free_tag == TWID'(i)))        w_clr[i] = 1'b1;
    end
  end

  // Number of allocated tags
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < OUTS; i++) w_cnt = w_cnt + CW'(r_map[i]);
  end

  // Occupancy bitmap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_map <= '0;
    else if (i_clr) r_map <= '0;
    else            r_map <= (r_map | w_set) & ~w_clr;
  end

  assign o_map      = r_map;
  assign o_avail    = w_avail;
  assign o_free_tag = w_idx;
  assign o_count    = w_cnt;

endmodule
`default_nettype wire

// File: rtl/syncfifo.sv
`default_nettype none
// ============================================================================
// Module   : syncfifo
// Purpose  : Single-clock FIFO with synchronous clear; head is shown
//            combinationally on o_dout.
// Revision : 1.0 - initial release
// ============================================================================
module syncfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage array; contents are don't-care while empty so it carries no reset
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= f_inc(r_wptr);
      if (i_pop)  r_rptr <= f_inc(r_rptr);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/rou_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : rou_endpoint
// Purpose  : Agent attachment for one rou switch port: packs requests into
//            messages with read-tag allocation, retires read responses.
// Revision : 1.0 - initial release
// ============================================================================
module rou_endpoint
  import rou_pkg::*;
#(
  parameter int DWID   = 128,
  parameter int AWID   = 32,
  parameter int TWID   = 5,
  parameter int BWID   = rou_bwid(DWID),
  parameter int WID    = 2 + DWID + AWID + BWID + TWID,
  parameter int OUTS   = 8,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      softreset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [AWID-1:0]           req_addr,
  input  logic [DWID-1:0]           req_data,
  input  logic [BWID-1:0]           req_bytes,
  input  logic                      req_seen,
  output logic [TWID-1:0]           req_tag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [TWID-1:0]           rsp_tag,
  output logic [DWID-1:0]           rsp_data,
  output logic [BWID-1:0]           rsp_bytes,
  output logic [WID-1:0]            rou_in,
  output logic                      rou_in_seen,
  input  logic [2:0]                ack_in,
  input  logic [WID-1:0]            rou_out,
  input  logic                      rou_out_seen,
  output logic [2:0]                ack_out,
  output logic [$clog2(OUTS+1)-1:0] outstanding,
  output logic                      err_badtag,
  output logic                      err_unexpected
);

  localparam int DATA_LSB  = ADDR_LSB + AWID;
  localparam int BYTES_LSB = DATA_LSB + DWID;
  localparam int TAG_LSB   = BYTES_LSB + BWID;
  localparam int RXW       = TWID + DWID + BWID;

  // ---------------- TX path ----------------
  logic [OUTS-1:0] w_map;
  logic            w_avail;
  logic [TWID-1:0] w_free_tag;
  logic            w_tx_empty;
  logic            w_tx_full;
  logic [WID:0]    w_tx_head;
  logic [WID:0]    w_tx_din;
  logic            w_req_fire;
  logic            w_tx_pop;

  assign req_ready  = !w_tx_full && (req_write || w_avail);
  assign req_tag    = req_write ? {TWID{1'b1}} : w_free_tag;
  assign w_req_fire = req_valid && req_ready;
  assign w_tx_pop   = !w_tx_empty && ack_in[0];

  // Seen flag rides above the message; read data is zeroed since it means nothing
  assign w_tx_din = {req_seen, req_tag, req_bytes,
                     (req_write ? req_data : {DWID{1'b0}}), req_addr,
                     (req_write ? KIND_WRITE : KIND_RDREQ)};

  syncfifo #(.WIDTH(WID + 1), .DEPTH(QDEPTH)) u_txq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (softreset),
    .i_push  (w_req_fire),
    .i_din   (w_tx_din),
    .i_pop   (w_tx_pop),
    .o_dout  (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full)
  );

  assign rou_in      = w_tx_empty ? '0 : w_tx_head[WID-1:0];
  assign rou_in_seen = !w_tx_empty && w_tx_head[WID];

  // ---------------- RX path ----------------
  logic [1:0]      w_rx_kind;
  logic [TWID-1:0] w_rx_tag;
  logic            w_rx_ack;
  logic            w_rx_full;
  logic            w_rx_empty;
  logic            w_rx_push;
  logic            w_tag_hit;
  logic [RXW-1:0]  w_rx_head;
  logic            w_unused;

  assign w_rx_kind = rou_out[KIND_LSB +: KIND_W];
  assign w_rx_tag  = rou_out[TAG_LSB +: TWID];
  // Every non-empty message is taken under the same condition, drops included
  assign w_rx_ack  = msgValid(w_rx_kind) && !w_rx_full;
  assign ack_out   = {2'b00, w_rx_ack};

  // Incoming tag names a currently allocated slot (out-of-range tags never hit)
  always_comb begin
    w_tag_hit = 1'b0;
    for (int i = 0; i < OUTS; i++) begin
      if ((w_rx_tag == TWID'(i)) && w_map[i]) w_tag_hit = 1'b1;
    end
  end

  assign w_rx_push = w_rx_ack && (w_rx_kind == KIND_RDRSP) && w_tag_hit;

  rou_tag_alloc #(.OUTS(OUTS), .TWID(TWID)) u_tags (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (softreset),
    .i_alloc    (w_req_fire && !req_write),
    .i_free     (w_rx_push),
    .i_free_tag (w_rx_tag),
    .o_map      (w_map),
    .o_avail    (w_avail),
    .o_free_tag (w_free_tag),
    .o_count    (outstanding)
  );

  syncfifo #(.WIDTH(RXW), .DEPTH(QDEPTH)) u_rxq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (softreset),
    .i_push  (w_rx_push),
    .i_din   ({w_rx_tag, rou_out[DATA_LSB +: DWID], rou_out[BYTES_LSB +: BWID]}),
    .i_pop   (rsp_valid && rsp_ready),
    .o_dout  (w_rx_head),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  assign rsp_valid = !w_rx_empty;
  assign {rsp_tag, rsp_data, rsp_bytes} = w_rx_head;

  // Sticky error flags for dropped messages
  logic r_err_badtag;
  logic r_err_unexp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_badtag <= 1'b0;
      r_err_unexp  <= 1'b0;
    end else if (softreset) begin
      r_err_badtag <= 1'b0;
      r_err_unexp  <= 1'b0;
    end else begin
      if (w_rx_ack && (w_rx_kind == KIND_RDRSP) && !w_tag_hit)
        r_err_badtag <= 1'b1;
      if (w_rx_ack && ((w_rx_kind == KIND_WRITE) || (w_rx_kind == KIND_RDREQ)))
        r_err_unexp <= 1'b1;
    end
  end

  assign err_badtag     = r_err_badtag;
  assign err_unexpected = r_err_unexp;

  // Address of inbound responses, the inbound seen flag and upper ack bits carry no meaning here
  assign w_unused = ^{rou_out[ADDR_LSB +: AWID], rou_out_seen, ack_in[2:1]};

endmodule
`default_nettype wire
